// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with PC, in-order request tracking and response buffering
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] inst_b,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        halted
);
  localparam int CW = 3;
  localparam logic [CW-1:0] LIM = CW'(DEPTH);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [0:0] S_RUN = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;

  logic [0:0]    r_state;
  logic [31:0]   r_pc;
  logic [CW-1:0] r_out, r_drop, r_bcnt, r_pcnt;
  logic [63:0]   r_buf [DEPTH];
  logic [31:0]   r_pq [DEPTH];
  logic [63:0]   w_buf_n [DEPTH];
  logic [31:0]   w_pq_n [DEPTH];
  logic [CW-1:0] w_bcnt_n, w_pcnt_n, w_out_n;
  logic [31:0]   w_rpc;
  logic w_run, w_redir, w_hgo, w_acc, w_resp, w_keep, w_bpop, w_byp, w_bpush;

  assign w_run     = r_state == S_RUN;
  assign imem_req  = !rst && w_run && !redirect && !halt && (r_out + r_bcnt < LIM);
  assign imem_addr = r_pc;
  assign w_acc     = imem_req && imem_gnt;
  assign w_resp    = imem_rvalid && r_out != '0;
  assign w_keep    = w_resp && r_drop == '0;
  assign w_redir   = w_run && redirect;
  assign w_hgo     = w_run && halt && !redirect;
  assign w_bpop    = !stall && r_bcnt != '0;
  assign w_byp     = w_keep && !stall && r_bcnt == '0;
  assign w_bpush   = w_keep && !w_byp;
  assign w_out_n   = r_out + CW'(w_acc) - CW'(w_resp);
  assign w_rpc     = redirect_pc & 32'hFFFF_FFFC;
  assign halted    = r_state == S_HALT;

  // next contents of the response buffer and PC queue (shift-out head, append at tail)
  always_comb begin
    w_buf_n  = r_buf;
    w_pq_n   = r_pq;
    w_bcnt_n = r_bcnt;
    w_pcnt_n = r_pcnt;
    if (w_bpop) begin
      for (int k = 0; k < DEPTH - 1; k++) w_buf_n[k] = r_buf[k+1];
      w_bcnt_n = r_bcnt - ONE;
    end
    if (w_bpush)
      for (int k = 0; k < DEPTH; k++) if (CW'(k) == w_bcnt_n) w_buf_n[k] = {imem_rdata, r_pq[0]};
    w_bcnt_n = w_bcnt_n + CW'(w_bpush);
    if (w_keep) begin
      for (int k = 0; k < DEPTH - 1; k++) w_pq_n[k] = r_pq[k+1];
      w_pcnt_n = r_pcnt - ONE;
    end
    if (w_acc)
      for (int k = 0; k < DEPTH; k++) if (CW'(k) == w_pcnt_n) w_pq_n[k] = r_pc;
    w_pcnt_n = w_pcnt_n + CW'(w_acc);
  end

  // storage arrays; validity is tracked by the counters alone
  always_ff @(posedge clk) begin
    r_buf <= w_buf_n;
    r_pq  <= w_pq_n;
  end

  // PC, state, counters and output register; redirect overrides stall and halt
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_pc       <= RESET_PC;
      r_out      <= '0;
      r_drop     <= '0;
      r_bcnt     <= '0;
      r_pcnt     <= '0;
      inst_b     <= NOP;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
    end else begin
      r_out  <= w_out_n;
      r_drop <= r_drop - CW'(w_resp && r_drop != '0);
      r_bcnt <= w_bcnt_n;
      r_pcnt <= w_pcnt_n;
      if (w_acc) r_pc <= r_pc + 32'd4;
      if (w_bpop) begin
        inst_b     <= r_buf[0][63:32];
        inst_pc    <= r_buf[0][31:0];
        inst_valid <= 1'b1;
      end else if (w_byp) begin
        inst_b     <= imem_rdata;
        inst_pc    <= r_pq[0];
        inst_valid <= 1'b1;
      end else if (!stall) begin
        inst_b     <= NOP;
        inst_valid <= 1'b0;
      end
      if (w_redir) begin
        r_pc       <= w_rpc;
        r_drop     <= w_out_n;
        r_bcnt     <= '0;
        r_pcnt     <= '0;
        inst_b     <= NOP;
        inst_valid <= 1'b0;
      end else if (w_hgo) begin
        r_state <= S_HALT;
        r_drop  <= w_out_n;
        r_bcnt  <= '0;
        r_pcnt  <= '0;
        if (!stall) begin
          inst_b     <= NOP;
          inst_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench with a latency-configurable memory and in-order delivery checks
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_gnt, imem_rvalid, stall, redirect, halt, inst_valid, halted;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst_b, inst_pc;
  int          n_vec = 0, n_bad = 0, cyc = 0, lat = 1;
  logic [31:0] exp_pc, exp_req;
  logic [31:0] q_addr [$];
  int          q_due [$];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(2), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .inst_b(inst_b), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .halted(halted)
  );

  function automatic logic [31:0] wd(input logic [31:0] a);
    return a ^ 32'hA5C3_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // one clock: record accept, advance memory model, check newly loaded output, drive response
  task automatic step();
    logic acc, rv, st, rs;
    logic [31:0] a;
    #1;
    acc = imem_req & imem_gnt;
    rv  = imem_rvalid;
    st  = stall;
    rs  = rst;
    a   = imem_addr;
    if (acc) begin
      chk("req_addr", a, exp_req);
      exp_req = exp_req + 32'd4;
    end
    @(posedge clk);
    #1;
    if (rs) begin
      q_addr.delete();
      q_due.delete();
    end else begin
      if (rv) begin
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
      if (acc) begin
        q_addr.push_back(a);
        q_due.push_back(cyc + lat);
      end
      chk("outstanding_le2", (q_addr.size() <= 2) ? 32'd1 : 32'd0, 32'd1);
    end
    cyc++;
    if (!rs && !st && inst_valid) begin
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst_b", inst_b, wd(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    @(negedge clk);
    if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = wd(q_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    halt = 1'b0;
    imem_gnt = 1'b1;
    imem_rvalid = 1'b0;
    #1 chk("req_in_rst", imem_req, 0);
    step();
    step();
    rst = 1'b0;
    cyc = 0;
    exp_pc = 32'h0;
    exp_req = 32'h0;
  endtask

  initial begin
    rst = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
    exp_pc = 32'h0; exp_req = 32'h0;
    // streaming with a 1-cycle memory
    lat = 1;
    do_reset();
    chk("rst_valid", inst_valid, 0);
    chk("rst_b", inst_b, NOP);
    chk("rst_pc", inst_pc, 0);
    chk("rst_halted", halted, 0);
    for (int i = 0; i < 6; i++) begin
      if (i == 1) chk("c1_valid", inst_valid, 0);
      if (i == 2) begin
        chk("c2_valid", inst_valid, 1);
        chk("c2_pc", inst_pc, 32'h0);
      end
      if (i == 3) #1 chk("c3_addr", imem_addr, 32'hC);
      step();
    end
    // five-cycle stall mid-stream
    chk("pre_stall_pc", inst_pc, 32'h10);
    stall = 1'b1;
    for (int i = 6; i < 11; i++) begin
      if (i > 6) begin
        chk("stall_pc", inst_pc, 32'h10);
        chk("stall_b", inst_b, wd(32'h10));
      end
      step();
    end
    stall = 1'b0;
    chk("stall_hold", inst_pc, 32'h10);
    for (int i = 11; i < 16; i++) begin
      if (i == 12) chk("post_stall_pc", inst_pc, 32'h14);
      if (i == 13) begin
        chk("post_stall_v", inst_valid, 1);
        chk("post_stall_pc2", inst_pc, 32'h18);
      end
      if (i == 14) chk("post_stall_pc3", inst_pc, 32'h1C);
      step();
    end
    // redirect with two responses in flight, 2-cycle memory
    lat = 2;
    do_reset();
    for (int i = 0; i < 8; i++) step();
    chk("redir_inflight", q_addr.size(), 2);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    exp_pc = 32'h100;
    exp_req = 32'h100;
    #1 chk("redir_req", imem_req, 0);
    step();
    redirect = 1'b0;
    chk("redir_bubble1", inst_valid, 0);
    chk("redir_nop", inst_b, NOP);
    #1 chk("redir_req2", imem_req, 1);
    chk("redir_addr", imem_addr, 32'h100);
    step();
    chk("redir_bubble2", inst_valid, 0);
    step();
    chk("redir_bubble3", inst_valid, 0);
    step();
    chk("redir_valid", inst_valid, 1);
    chk("redir_pc", inst_pc, 32'h100);
    for (int i = 0; i < 5; i++) step();
    // 3-cycle memory with alternating grant and a short stall
    lat = 3;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      imem_gnt = (i % 2 == 0);
      stall = (i >= 12 && i < 15);
      step();
    end
    imem_gnt = 1'b1;
    stall = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("l3_progress", (exp_pc >= 32'h20) ? 32'd1 : 32'd0, 32'd1);
    // halt, ignored redirect while halted, then reset
    lat = 1;
    do_reset();
    for (int i = 0; i < 10; i++) step();
    chk("halt_at_pc", inst_pc, 32'h20);
    chk("halt_at_v", inst_valid, 1);
    halt = 1'b1;
    #1 chk("halt_req", imem_req, 0);
    step();
    halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        redirect = 1'b1;
        redirect_pc = 32'h200;
      end
      chk("halted", halted, 1);
      chk("halted_valid", inst_valid, 0);
      chk("halted_b", inst_b, NOP);
      #1 chk("halted_req", imem_req, 0);
      step();
      redirect = 1'b0;
    end
    chk("halted_after_redir", halted, 1);
    do_reset();
    chk("unhalt", halted, 0);
    #1 chk("unhalt_req", imem_req, 1);
    chk("unhalt_addr", imem_addr, 32'h0);
    // redirect + halt + stall together
    for (int i = 0; i < 6; i++) step();
    chk("rhs_pre_pc", inst_pc, 32'h10);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    halt = 1'b1;
    stall = 1'b1;
    exp_pc = 32'h40;
    exp_req = 32'h40;
    #1 chk("rhs_req", imem_req, 0);
    step();
    redirect = 1'b0;
    halt = 1'b0;
    stall = 1'b0;
    chk("rhs_halted", halted, 0);
    chk("rhs_valid", inst_valid, 0);
    chk("rhs_b", inst_b, NOP);
    #1 chk("rhs_req2", imem_req, 1);
    chk("rhs_addr", imem_addr, 32'h40);
    step();
    step();
    chk("rhs_valid2", inst_valid, 1);
    chk("rhs_pc", inst_pc, 32'h40);
    for (int i = 0; i < 3; i++) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
